// File: rtl/arcade_input_mapper.sv
// Arcade input front end: PS/2 key decode merged with MiSTer joystick words, rotation, coin stretch, autofire.
// Define ARCADE_INPUT_AUTOFIRE_EN to build per-player autofire; without it fire passes straight through.
module arcade_input_mapper #(
    parameter int          PLAYERS      = 2,
    parameter logic [15:0] COIN_HOLD    = 16'd60000,
    parameter logic [19:0] AUTOFIRE_DIV = 20'd400000
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [10:0]            ps2_key,
    input  logic [16*PLAYERS-1:0]  joy,
    input  logic                   rotate,
    input  logic [PLAYERS-1:0]     autofire_en,
    output logic [8*PLAYERS-1:0]   btn,
    output logic                   key_event
);
    localparam int NKEYS = 18;

    // Entry layout {ext_dont_care, ext, scan_code}; 0..9 belong to player 0, 10..17 to player 1
    localparam logic [9:0] KEY_MAP [NKEYS] = '{
        10'h275, 10'h272, 10'h26B, 10'h274, 10'h029, 10'h214, 10'h005, 10'h016, 10'h02E, 10'h02C,
        10'h02D, 10'h02B, 10'h023, 10'h034, 10'h01C, 10'h006, 10'h01E, 10'h036
    };

    logic             tog_reg;
    logic             primed_reg;
    logic             key_event_reg;
    logic             event_w;
    logic [NKEYS-1:0] key_state;

    assign event_w   = primed_reg && (ps2_key[10] != tog_reg);
    assign key_event = key_event_reg;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_reg       <= 1'b0;
            primed_reg    <= 1'b0;
            key_event_reg <= 1'b0;
        end else begin
            tog_reg       <= ps2_key[10];
            primed_reg    <= 1'b1;
            key_event_reg <= event_w;
        end
    end

    genvar gi;

    for (gi = 0; gi < NKEYS; gi++) begin : g_key
        localparam logic [9:0] ENTRY  = KEY_MAP[gi];
        localparam bit         USABLE = (gi < 10) || (PLAYERS > 1);
        logic hit;
        logic state_reg;

        assign hit = USABLE && (ps2_key[7:0] == ENTRY[7:0]) && (ENTRY[9] || (ps2_key[8] == ENTRY[8]));
        assign key_state[gi] = state_reg;

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n)
                state_reg <= 1'b0;
            else if (event_w && hit)
                state_reg <= ps2_key[9];
        end
    end

    for (gi = 0; gi < PLAYERS; gi++) begin : g_player
        logic [15:0] joy_p;
        logic [7:0]  key_p;
        logic        right_raw, left_raw, down_raw, up_raw;
        logic        fire_raw, start_raw, coin_raw, test_raw;
        logic        fire_out, coin_out;
        logic        coin_prev_reg;
        logic [15:0] coin_cnt_reg, coin_cnt_next;
        logic [7:0]  btn_reg, btn_next;
        logic        unused_joy;

        assign joy_p      = joy[16*gi +: 16];
        assign unused_joy = ^{joy_p[15:8], joy_p[6]};

        // key_p uses the btn bit layout: {test, coin, start, fire, up, down, left, right}
        if (gi == 0) begin : g_keys_p0
            assign key_p = {key_state[9], key_state[8], key_state[6] | key_state[7],
                            key_state[4] | key_state[5], key_state[0], key_state[1],
                            key_state[2], key_state[3]};
        end else if (gi == 1) begin : g_keys_p1
            assign key_p = {1'b0, key_state[17], key_state[15] | key_state[16],
                            key_state[14], key_state[10], key_state[11],
                            key_state[12], key_state[13]};
        end else begin : g_keys_none
            assign key_p = 8'h00;
        end

        assign right_raw = key_p[0] | joy_p[0];
        assign left_raw  = key_p[1] | joy_p[1];
        assign down_raw  = key_p[2] | joy_p[2];
        assign up_raw    = key_p[3] | joy_p[3];
        assign fire_raw  = key_p[4] | joy_p[4];
        assign start_raw = key_p[5] | joy_p[5];
        assign coin_raw  = key_p[6] | joy_p[7];
        assign test_raw  = key_p[7];

        // A rising edge always reloads, so a second coin while stretching extends the pulse
        always_comb begin
            coin_cnt_next = coin_cnt_reg;
            if (coin_raw && !coin_prev_reg)
                coin_cnt_next = COIN_HOLD;
            else if (coin_cnt_reg != 16'd0)
                coin_cnt_next = coin_cnt_reg - 16'd1;
        end

        assign coin_out = coin_raw || (coin_cnt_reg != 16'd0);

`ifdef ARCADE_INPUT_AUTOFIRE_EN
        logic        fire_prev_reg;
        logic        fire_rise;
        logic        af_phase_reg, af_phase_eff, af_phase_next;
        logic [19:0] af_cnt_reg, af_cnt_eff, af_cnt_next;

        assign fire_rise = fire_raw && !fire_prev_reg;

        // The press cycle counts as the first cycle of the on phase, so the first shot is immediate
        always_comb begin
            af_cnt_eff    = fire_rise ? 20'd0 : af_cnt_reg;
            af_phase_eff  = fire_rise || af_phase_reg;
            af_cnt_next   = 20'd0;
            af_phase_next = 1'b0;
            if (fire_raw) begin
                if (af_cnt_eff == AUTOFIRE_DIV - 20'd1) begin
                    af_cnt_next   = 20'd0;
                    af_phase_next = !af_phase_eff;
                end else begin
                    af_cnt_next   = af_cnt_eff + 20'd1;
                    af_phase_next = af_phase_eff;
                end
            end
        end

        assign fire_out = fire_raw && (af_phase_eff || !autofire_en[gi]);

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                fire_prev_reg <= 1'b0;
                af_cnt_reg    <= 20'd0;
                af_phase_reg  <= 1'b0;
            end else begin
                fire_prev_reg <= fire_raw;
                af_cnt_reg    <= af_cnt_next;
                af_phase_reg  <= af_phase_next;
            end
        end
`else
        logic unused_af;
        assign unused_af = autofire_en[gi];
        assign fire_out  = fire_raw;
`endif

        always_comb begin
            btn_next    = 8'h00;
            btn_next[0] = rotate ? up_raw    : right_raw;
            btn_next[1] = rotate ? down_raw  : left_raw;
            btn_next[2] = rotate ? right_raw : down_raw;
            btn_next[3] = rotate ? left_raw  : up_raw;
            btn_next[4] = fire_out;
            btn_next[5] = start_raw;
            btn_next[6] = coin_out;
            btn_next[7] = test_raw;
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                coin_prev_reg <= 1'b0;
                coin_cnt_reg  <= 16'd0;
                btn_reg       <= 8'h00;
            end else begin
                coin_prev_reg <= coin_raw;
                coin_cnt_reg  <= coin_cnt_next;
                btn_reg       <= btn_next;
            end
        end

        assign btn[8*gi +: 8] = btn_reg;
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: stimulus pushes per-edge expectations, a monitor pops and compares.
module tb_arcade_input_mapper;
    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [31:0] joy;
    logic        rotate;
    logic [1:0]  autofire_en;
    logic [15:0] btn;
    logic        key_event;
    logic [7:0]  btn1;
    logic        key_event1;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] btn;
        logic        ev;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam bit AF_BUILT = 1'b1;
`else
    localparam bit AF_BUILT = 1'b0;
`endif

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(
        .PLAYERS(2), .COIN_HOLD(16'd10), .AUTOFIRE_DIV(20'd4)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy(joy),
        .rotate(rotate), .autofire_en(autofire_en), .btn(btn), .key_event(key_event)
    );

    // Single-player instance sees player 0's inputs; its outputs must always equal player 0's byte
    arcade_input_mapper #(
        .PLAYERS(1), .COIN_HOLD(16'd10), .AUTOFIRE_DIV(20'd4)
    ) dut1 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy(joy[15:0]),
        .rotate(rotate), .autofire_en(autofire_en[0]), .btn(btn1), .key_event(key_event1)
    );

    task automatic step(input logic [15:0] eb, input logic ev, input string tag);
        exp_t e;
        e.btn = eb;
        e.ev  = ev;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic send(input logic pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
    endtask

    initial begin
        exp_t  e;
        string t;
        forever begin
            @(posedge clk_sys);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                t = tag_q.pop_front();
                total++;
                if (btn !== e.btn || key_event !== e.ev || btn1 !== e.btn[7:0] || key_event1 !== e.ev) begin
                    bad++;
                    $display("FAIL %s: got btn=%h ev=%b btn1=%h ev1=%b, want btn=%h ev=%b btn1=%h ev1=%b",
                             t, btn, key_event, btn1, key_event1, e.btn, e.ev, e.btn[7:0], e.ev);
                end else begin
                    $display("ok   %s: btn=%h ev=%b btn1=%h", t, btn, key_event, btn1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic f;
        reset_n     = 1'b0;
        ps2_key     = 11'h400;
        joy         = 32'h0;
        rotate      = 1'b0;
        autofire_en = 2'b00;
        step(16'h0000, 1'b0, "reset");
        step(16'h0000, 1'b0, "reset");

        // Stale toggle high at release must not produce an event
        reset_n = 1'b1;
        repeat (4) step(16'h0000, 1'b0, "stale_toggle");

        send(1'b1, 9'h175);
        step(16'h0000, 1'b0 | 1'b1, "up_press_evt");
        step(16'h0008, 1'b0, "up_press_btn");
        send(1'b0, 9'h175);
        step(16'h0008, 1'b1, "up_rel_evt");
        step(16'h0000, 1'b0, "up_rel_btn");

        // Space requires non-extended code; unmapped codes still pulse
        send(1'b1, 9'h129);
        step(16'h0000, 1'b1, "ext_space_evt");
        step(16'h0000, 1'b0, "ext_space_ignored");
        send(1'b1, 9'h0AA);
        step(16'h0000, 1'b1, "unmapped_evt");
        step(16'h0000, 1'b0, "unmapped_btn");

        rotate = 1'b1; joy = 32'h0000_0002;
        step(16'h0008, 1'b0, "rot_left_to_up");
        rotate = 1'b0;
        step(16'h0002, 1'b0, "norot_left");
        rotate = 1'b1; joy = 32'h0000_0004;
        step(16'h0002, 1'b0, "rot_down_to_left");
        joy = 32'h0000_0001;
        step(16'h0004, 1'b0, "rot_right_to_down");
        joy = 32'h0008_0000;
        step(16'h0100, 1'b0, "rot_p1_up_to_right");
        rotate = 1'b0; joy = 32'h0;
        step(16'h0000, 1'b0, "rot_idle");

        // One-cycle coin key: 11 cycles of coin out
        send(1'b1, 9'h02E);
        step(16'h0000, 1'b1, "coin_key_evt");
        send(1'b0, 9'h02E);
        step(16'h0040, 1'b1, "coin_key_rel");
        repeat (10) step(16'h0040, 1'b0, "coin_hold");
        step(16'h0000, 1'b0, "coin_end");

        // Retrigger on the 6th high cycle stretches to 16 cycles
        joy = 32'h0000_0080;
        step(16'h0040, 1'b0, "jcoin_first");
        joy = 32'h0;
        repeat (4) step(16'h0040, 1'b0, "jcoin_hold");
        joy = 32'h0000_0080;
        step(16'h0040, 1'b0, "jcoin_retrig");
        joy = 32'h0;
        repeat (10) step(16'h0040, 1'b0, "jcoin_hold2");
        step(16'h0000, 1'b0, "jcoin_end");

        send(1'b1, 9'h01C);
        step(16'h0000, 1'b1, "p1_fire_evt");
        step(16'h1000, 1'b0, "p1_fire_btn");
        send(1'b0, 9'h01C);
        step(16'h1000, 1'b1, "p1_fire_rel_evt");
        step(16'h0000, 1'b0, "p1_fire_rel_btn");

        send(1'b1, 9'h036);
        step(16'h0000, 1'b1, "p1_coin_evt");
        send(1'b0, 9'h036);
        step(16'h4000, 1'b1, "p1_coin_rel");
        repeat (10) step(16'h4000, 1'b0, "p1_coin_hold");
        step(16'h0000, 1'b0, "p1_coin_end");

        // Space and ctrl OR together; right ctrl (extended) shares the ctrl register
        send(1'b1, 9'h029);
        step(16'h0000, 1'b1, "space_evt");
        step(16'h0010, 1'b0, "space_btn");
        send(1'b1, 9'h014);
        step(16'h0010, 1'b1, "ctrl_evt");
        step(16'h0010, 1'b0, "both_fire");
        send(1'b0, 9'h029);
        step(16'h0010, 1'b1, "space_rel_evt");
        step(16'h0010, 1'b0, "ctrl_still_held");
        step(16'h0010, 1'b0, "ctrl_still_held");
        send(1'b0, 9'h114);
        step(16'h0010, 1'b1, "ctrl_rel_evt");
        step(16'h0000, 1'b0, "fire_clear");

        send(1'b1, 9'h016);
        step(16'h0000, 1'b1, "start_evt");
        step(16'h0020, 1'b0, "start_btn");
        send(1'b0, 9'h016);
        step(16'h0020, 1'b1, "start_rel_evt");
        step(16'h0000, 1'b0, "start_clear");

        send(1'b1, 9'h02C);
        step(16'h0000, 1'b1, "test_evt");
        step(16'h0080, 1'b0, "test_btn");
        send(1'b0, 9'h02C);
        step(16'h0080, 1'b1, "test_rel_evt");
        step(16'h0000, 1'b0, "test_clear");

        // Key event and joystick change on the same edge
        send(1'b1, 9'h06B); joy = 32'h0000_0001;
        step(16'h0001, 1'b1, "simul_evt");
        step(16'h0003, 1'b0, "simul_both");
        send(1'b0, 9'h06B); joy = 32'h0;
        step(16'h0002, 1'b1, "simul_rel");
        step(16'h0000, 1'b0, "simul_clear");

        // Player 0 autofire enabled, player 1 held steady
        joy = 32'h0010_0010; autofire_en = 2'b01;
        for (int i = 0; i < 20; i++) begin
            f = AF_BUILT ? (((i / 4) % 2) == 0) : 1'b1;
            step({8'h10, 3'b000, f, 4'b0000}, 1'b0, "autofire");
        end
        joy = 32'h0;
        step(16'h0000, 1'b0, "af_release");
        autofire_en = 2'b00;

        // Reset during a coin stretch and with a pending toggle leaves nothing behind
        joy = 32'h0000_0080;
        step(16'h0040, 1'b0, "pre_rst_coin");
        joy = 32'h0;
        step(16'h0040, 1'b0, "pre_rst_hold");
        step(16'h0040, 1'b0, "pre_rst_hold");
        reset_n = 1'b0;
        send(1'b1, 9'h175);
        step(16'h0000, 1'b0, "rst_mid_stretch");
        reset_n = 1'b1;
        step(16'h0000, 1'b0, "post_rst_prime");
        repeat (3) step(16'h0000, 1'b0, "post_rst_idle");

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arcade_input_mapper.md
# arcade_input_mapper

Parametrised input front end for arcade cores. Decodes PS/2 key events into per-player button state and merges them with MiSTer joystick words. Applies orientation rotation, coin pulse stretching and optional per-player autofire, producing one registered 8-bit button vector per player for the core. Sits between `hps_io` and the game module, replacing ad-hoc per-core key decoding.

## Interface
- `PLAYERS`, 2: player channels, 1..4. Keyboard keys exist for players 0 and 1 only.
- `COIN_HOLD`, 16'd60000: minimum coin assertion in `clk_sys` cycles, 1..65535.
- `AUTOFIRE_DIV`, 20'd400000: cycles per autofire half-period, 1..2^20-1.

Ports:
- `clk_sys` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_key` in 11: bit [10] is the event toggle, [9] pressed, [8] extended, [7:0] scan code.
- `joy` in 16*PLAYERS: player p joystick at `joy[16*p +: 16]`. Bits: [0] right, [1] left, [2] down, [3] up, [4] fire, [5] start, [7] coin.
- `rotate` in 1: 1 = horizontal-mode direction remap.
- `autofire_en` in PLAYERS: per-player autofire request.
- `btn` out 8*PLAYERS: player p at `btn[8*p +: 8]`. Bits: [0] right, [1] left, [2] down, [3] up, [4] fire, [5] start, [6] coin, [7] test (player 0 only, 0 elsewhere).
- `key_event` out 1: one-cycle pulse per decoded PS/2 event.

## Operation
- Event detect: event when `ps2_key[10]` differs from registered `tog_q`; `tog_q` updates every cycle.
  - A `primed` flag, cleared by reset, suppresses event detection on the first cycle after reset release. That cycle only loads `tog_q`, so a stale toggle produces no event.
- Key state registers, on an event, are set to `ps2_key[9]` on code match. Extended bit is don't-care where marked X.
  - P0: X75 up, X72 down, X6B left, X74 right, 029 fire, X14 fire, 005 start, 016 start, 02E coin, 02C test.
  - P1: 02D up, 02B down, 023 left, 034 right, 01C fire, 006 start, 01E start, 036 coin.
  - Keys mapped to the same function (for example space and ctrl) are OR-ed, each with its own state register.
  - Unmapped codes leave state unchanged but still pulse `key_event`.
  - P1 keys are ignored when `PLAYERS`=1.
- Raw merge per player: raw = key state OR joystick bit.
- Rotation, when `rotate`=1: up←raw left, down←raw right, left←raw down, right←raw up. When `rotate`=0, direction bits pass through.
- Coin stretcher, per player, 16-bit counter:
  - Raw coin rising edge loads `COIN_HOLD`.
  - Counter decrements to 0 and holds there.
  - Coin out = raw coin OR counter≠0.
  - A rising edge while the counter is nonzero reloads it (retrigger).
- Autofire, per player, phase counter plus phase bit:
  - Fire rising edge clears the counter and sets phase=1, so the first shot is immediate.
  - While fire is held, phase toggles each `AUTOFIRE_DIV` cycles.
  - Fire out = raw fire AND (phase OR NOT `autofire_en[p]`).
  - Fire release clears phase.

## Timing
- Reset: all key states, `tog_q`, `primed`, counters, phase, `btn` and `key_event` go to 0.
- PS/2 event sampled at edge k: key state updates at edge k, `key_event` is high for the cycle after edge k, `btn` updates at edge k+1.
- Joystick/rotate change sampled at edge k: `btn` updates at edge k (1 register).
- Coin: a 1-cycle raw pulse yields exactly `COIN_HOLD`+1 cycles of coin out.
- Autofire: with fire held and enabled, fire out is high `AUTOFIRE_DIV` cycles, then low `AUTOFIRE_DIV` cycles, repeating.
- Simultaneous PS/2 event and joystick change on one edge: both are applied; OR-merge makes ordering irrelevant.
- `reset_n` deasserted mid-event or mid-stretch: all state clears immediately; no residual coin or fire.

## Configuration
- `ARCADE_INPUT_AUTOFIRE_EN` defined: autofire counters and phase logic are compiled in, as described above.
- Not defined: no autofire logic; `autofire_en` is ignored and fire out = raw fire.
- Coin and key logic are unaffected either way.

## Test plan
- Reset release with `ps2_key[10]`=1: no `key_event`, `btn`=0 for 4 cycles. Then toggle with code 0x175, pressed=1: `btn[3]`=1 two edges later, `key_event` 1 cycle.
- `rotate`=1, `joy[1]`=1 (left): `btn[3]`=1 (up), `btn[1]`=0. `rotate`=0: `btn[1]`=1.
- `COIN_HOLD`=10, key 0x02E press then release after 1 cycle: `btn[6]` high exactly 11 cycles. Second press at cycle 5 extends it to cycle 16.
- `PLAYERS`=2, key 0x01C pressed: `btn[12]`=1, `btn[4]`=0. With `PLAYERS`=1: no change, `key_event` still pulses.
- Autofire built in, `AUTOFIRE_DIV`=4, `autofire_en`=1, `joy[4]` held 20 cycles: fire out pattern 4 high/4 low from the first cycle. Release: fire low next edge.
- Space and ctrl both pressed, space released: `btn[4]` stays 1 until ctrl release.
